rx_lane_mux: RTL and testbench

RX_LANE_MUX -- requirements
Module: rx_lane_mux

---
 rtl/rx_lane_mux.sv | 155 +++++++++++++++
 tb/tb_rx_lane_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_mux.sv
// Multi-channel receive lane multiplexer with fixed or round-robin grant and a registered output beat.
// Optional feature: define RX_LANE_MUX_SKID_EN to add a 1-entry skid buffer so in_ready is registered-only.
module rx_lane_mux #(
  parameter int WIDTH = 64,
  parameter int SELW  = 2
) (
  input  logic                           rxclk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           mode,
  input  logic [SELW-1:0]                sel,
  input  logic                           sel_load,
  input  logic [(2**SELW)*WIDTH-1:0]     in_data,
  input  logic [(2**SELW)-1:0]           in_valid,
  output logic [(2**SELW)-1:0]           in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SELW-1:0]                out_ch
);

  localparam int NCH = 2**SELW;

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  cand;
  logic             found;
  logic [WIDTH-1:0] in_beat;
  logic             accept_ok;
  logic             xfer;

`ifdef RX_LANE_MUX_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  skid_ch_q, skid_ch_d;
  logic             out_free;
`endif

  // Round-robin searches upward from ptr with natural SELW-bit wrap; fixed mode and the
  // no-valid case both fall back to ptr.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    if (mode) begin
      for (int i = 0; i < NCH; i++) begin
        cand = ptr_q + SELW'(i);
        if (!found && in_valid[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign in_beat = in_data[int'(grant)*WIDTH +: WIDTH];

`ifdef RX_LANE_MUX_SKID_EN
  assign accept_ok = en & ~reset & ~skid_valid_q;
`else
  assign accept_ok = en & ~reset & (~out_valid_q | out_ready);
`endif

  always_comb begin
    in_ready        = '0;
    in_ready[grant] = accept_ok;
  end

  assign xfer = in_valid[grant] & in_ready[grant];

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
`ifdef RX_LANE_MUX_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ch_d    = skid_ch_q;
    out_free     = ~out_valid_q | out_ready;
`endif

    // A pointer load wins over the round-robin advance; the beat itself still uses this cycle's grant.
    if (sel_load) begin
      ptr_d = sel;
    end else if (mode && xfer) begin
      ptr_d = grant + SELW'(1);
    end

`ifdef RX_LANE_MUX_SKID_EN
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_ch_d     = skid_ch_q;
        skid_valid_d = 1'b0;
      end else if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_beat;
        out_ch_d    = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_beat;
      skid_ch_d    = grant;
    end
`else
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_beat;
      out_ch_d    = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data registers are reset too, because a cleared out_data/skid is part of the block's reset contract.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
`ifdef RX_LANE_MUX_SKID_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ch_q    <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
`ifdef RX_LANE_MUX_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ch_q    <= skid_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rx_lane_mux.sv
// Self-checking bench for rx_lane_mux: queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_lane_mux;

  localparam int W  = 64;
  localparam int SW = 2;
  localparam int N  = 4;

  logic            rxclk = 1'b0;
  logic            reset, en, mode, sel_load, out_ready, out_valid;
  logic [SW-1:0]   sel, out_ch;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic [W-1:0]    out_data;

  rx_lane_mux #(.WIDTH(W), .SELW(SW)) dut (
    .rxclk(rxclk), .reset(reset), .en(en), .mode(mode), .sel(sel), .sel_load(sel_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 rxclk = ~rxclk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } beat_t;

  // Beats accepted but not yet consumed downstream; front is what out_data must show.
  beat_t q[$];
  int    m_ptr = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (!mode) return m_ptr;
    for (int i = 0; i < N; i++)
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return m_ptr;
  endfunction

  function automatic bit m_space();
`ifdef RX_LANE_MUX_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] one;
    bit           xfer;
    beat_t        b;
    one = 1;
    @(negedge rxclk);
    if (reset) begin
      q.delete();
      m_ptr = 0;
    end
    g       = m_grant();
    exp_rdy = (en && !reset && m_space()) ? (one << g) : '0;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_ch", out_ch, q[0].ch);
    end
    @(posedge rxclk);
    if (reset) begin
      q.delete();
      m_ptr = 0;
    end else begin
      xfer = exp_rdy[g] && in_valid[g];
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (xfer) begin
        b.d  = in_data[g*W +: W];
        b.ch = SW'(g);
        q.push_back(b);
      end
      if (sel_load) m_ptr = int'(sel);
      else if (mode && xfer) m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  int exp_seq[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    reset = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; sel_load = 1'b0;
    in_data = '0; in_valid = '0; out_ready = 1'b0;
    #1 reset = 1'b1;
    cycle(); cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;

    // Fixed mode on channel 2
    in_data = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
               64'h1111_1111_1111_1111, 64'h0A0A_0A0A_0A0A_0A0A};
    en = 1'b1; out_ready = 1'b1; in_valid = 4'hF; mode = 1'b0;
    sel = 2'd2; sel_load = 1'b1;
    cycle();
    check("fixed_load_ch", out_ch, 0);
    sel_load = 1'b0;
    repeat (3) begin
      cycle();
      check("fixed_ch", out_ch, 2);
      check("fixed_data", out_data, 64'h2222_2222_2222_2222);
    end

    // Round-robin over 4'b1011 from ptr 0
    mode = 1'b1; in_valid = 4'b1011; sel = 2'd0; sel_load = 1'b1;
    cycle();
    sel_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_seq", out_ch, exp_seq[i]);
    end

    // Backpressure for three cycles, then drain
    out_ready = 1'b0;
    repeat (3) cycle();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (4) cycle();

    // en low drains the pending beat and blocks acceptance
    cycle();
    check("en1_valid", out_valid, 1);
    en = 1'b0;
    cycle();
    check("en0_valid", out_valid, 0);
    check("en0_ready", in_ready, 0);

    // sel_load colliding with a round-robin accept from channel 3
    en = 1'b1; in_valid = 4'b1000; sel = 2'd1; sel_load = 1'b1;
    cycle();
    check("sl_tag", out_ch, 3);
    sel_load = 1'b0; in_valid = 4'hF;
    cycle();
    check("sl_next", out_ch, 1);

    // Reset pulse while a beat is held
    check("pre_rst_valid", out_valid, 1);
    in_valid = '0; reset = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 0);
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    check("post_rst_valid", out_valid, 0);
    in_valid = 4'hF;
    cycle();
    check("post_rst_ch", out_ch, 0);
    check("post_rst_beat", out_valid, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) in_data[k*W +: W] = {$urandom(), $urandom()};
      in_valid  = N'($urandom());
      en        = ($urandom_range(7) != 0);
      out_ready = ($urandom_range(3) != 0);
      sel_load  = ($urandom_range(7) == 0);
      sel       = SW'($urandom());
      if ($urandom_range(15) == 0) mode = ~mode;
      reset     = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
